// File: rtl/display_hex_writer.sv
// display_hex_writer
//   Renders a 32-bit value as 8 ASCII hex characters into a character buffer,
//   one character per clock, most significant nibble first. One request can
//   be active while a second waits in a pending slot, so a steady producer
//   sees back-to-back writes with no idle cycle between requests.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no active request; charWE low
//   SEND  | writing beat 0..7 of the active request; charWE high
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   reqValid  in   request presented
//   reqRow    in   [1:0] display row of the request
//   reqData   in   [31:0] value to render
//   reqReady  out  pending slot free; request taken when reqValid && reqReady
//   charWE    out  character buffer write enable
//   charAddr  out  [5:0] {row, column}
//   charData  out  [7:0] ASCII character
//   busy      out  a request is being written or is waiting
module display_hex_writer #(
    parameter int CHAR_COLUMN_BASE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    input  logic [1:0]  reqRow,
    input  logic [31:0] reqData,
    output logic        reqReady,
    output logic        charWE,
    output logic [5:0]  charAddr,
    output logic [7:0]  charData,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stateType;

    localparam logic [3:0] COLUMN_BASE = 4'(CHAR_COLUMN_BASE);

    stateType    state;
    logic [2:0]  beat;
    logic [1:0]  activeRow;
    logic [31:0] activeData;
    logic        pendingValid;
    logic [1:0]  pendingRow;
    logic [31:0] pendingData;

    logic [31:0] shiftedData;
    logic [3:0]  nibble;

    assign reqReady = !pendingValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= 3'd0;
            activeRow    <= 2'd0;
            activeData   <= 32'd0;
            pendingValid <= 1'b0;
            pendingRow   <= 2'd0;
            pendingData  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= 3'd0;
                    if (pendingValid) begin
                        activeRow    <= pendingRow;
                        activeData   <= pendingData;
                        pendingValid <= 1'b0;
                        state        <= SEND;
                    end else if (reqValid) begin
                        activeRow  <= reqRow;
                        activeData <= reqData;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (beat != 3'd7) begin
                        beat <= beat + 3'd1;
                        if (reqValid && !pendingValid) begin
                            pendingValid <= 1'b1;
                            pendingRow   <= reqRow;
                            pendingData  <= reqData;
                        end
                    end else begin
                        // Last beat: chain straight into the next request so
                        // there is no gap in the write stream. A request seen
                        // while the pending slot is full was never accepted.
                        beat <= 3'd0;
                        if (pendingValid) begin
                            activeRow    <= pendingRow;
                            activeData   <= pendingData;
                            pendingValid <= 1'b0;
                        end else if (reqValid) begin
                            activeRow  <= reqRow;
                            activeData <= reqData;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= 3'd0;
                end
            endcase
        end
    end

    // Beat k shows nibble k counted from the top of the word.
    assign shiftedData = activeData << {beat, 2'b00};
    assign nibble      = shiftedData[31:28];

    assign charWE   = (state == SEND);
    assign busy     = (state == SEND) || pendingValid;
    assign charAddr = {activeRow, COLUMN_BASE + {1'b0, beat}};

    // 'A' is 8'h41, so A..F map to 8'h37 + nibble.
    assign charData = (nibble <= 4'd9) ? (8'h30 + {4'h0, nibble})
                                       : (8'h37 + {4'h0, nibble});

endmodule
